// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream adapters.
package stream_pkg;

  typedef enum logic [0:0] {
    eIDLE = 1'b0,
    eSEND = 1'b1
  } state_e;

  // Width of a counter that must hold 0..n-1. The width is never below one bit.
  function automatic int unsigned count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Saturating up-counter 0..LIMIT-1 with synchronous clear and an at-limit flag.
module beat_counter
  import stream_pkg::*;
#(
  parameter int unsigned LIMIT = 8,
  localparam int unsigned CW = count_width(LIMIT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] MAX = CW'(LIMIT - 1);

  // Count register: clear wins over enable, and the count stops at LIMIT-1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + CW'(1);
    end
  end

  assign at_limit = (count == MAX);

endmodule

// File: rtl/vector_serializer.sv
// Parallel-to-serial stream adapter: captures a DEPTH-word vector over a
// valid/ready handshake and emits it one WIDTH-bit word per beat, word 0 first.
module vector_serializer
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [DEPTH*WIDTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i
);

  localparam int unsigned CW = count_width(DEPTH);

  state_e                        state;
  state_e                        state_next;
  logic [DEPTH-1:0][WIDTH-1:0]   vec;
  logic [CW-1:0]                 idx;
  logic                          at_last;
  logic                          beat;
  logic                          in_fire;
  logic [WIDTH-1:0]              word;

  assign beat    = valid_o && ready_i;
  assign in_fire = valid_i && ready_o;

  // Beat index: advances on non-final beats and restarts at every capture or final beat.
  beat_counter #(
    .LIMIT (DEPTH)
  ) u_idx (
    .clk      (clk_i),
    .reset_n  (reset_n_i),
    .enable   (beat && !at_last),
    .clear    (in_fire || (beat && at_last)),
    .count    (idx),
    .at_limit (at_last)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= eIDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture register: loaded only when the input handshake fires.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vec <= '0;
    end else if (in_fire) begin
      vec <= data_i;
    end
  end

  // Next-state logic: a final beat either refills from upstream or returns to idle.
  always_comb begin
    state_next = state;
    unique case (state)
      eIDLE: begin
        if (valid_i) state_next = eSEND;
      end
      eSEND: begin
        if (beat && at_last) state_next = valid_i ? eSEND : eIDLE;
      end
      default: state_next = eIDLE;
    endcase
  end

  // A one-word vector has only index 0, so it skips the index mux.
  if (DEPTH == 1) begin : g_single
    assign word = vec[0];
  end else begin : g_multi
    assign word = vec[idx];
  end

  // Output decode from registered state; ready_o also looks at ready_i so a final beat can overlap the next capture.
  always_comb begin
    valid_o = (state == eSEND);
    last_o  = (state == eSEND) && at_last;
    ready_o = (state == eIDLE) || ((state == eSEND) && at_last && ready_i);
    data_o  = word;
  end

endmodule
